// File: rtl/keypad_4x4_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, debounces rows,
// emits one code per press and shifts codes into a 4-nibble history.
module keypad_4x4_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] value
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1) + 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN, DEBOUNCE, ACCEPT, PRESSED
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_m_q, row_m_d;
  logic [3:0]    row_s_q, row_s_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          down_q, down_d;
  logic [15:0]   value_q, value_d;

  logic          tick;
  logic          all_high;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    col_rot;
  logic [1:0]    cur_col_idx;
  logic [1:0]    cur_row_idx;

  assign tick     = (div_q == DIV_MAX);
  assign all_high = (row_s_q == 4'b1111);
  assign cnt_inc  = cnt_q + CW'(1);
  assign col_rot  = {col_q[2:0], col_q[3]};

  // Encode the driven column and the lowest active row.
  always_comb begin
    cur_col_idx = 2'd0;
    cur_row_idx = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (!col_q[j]) cur_col_idx = 2'(j);
      if (!row_s_q[j]) cur_row_idx = 2'(j);
    end
  end

  // Synchronizer, prescaler and scan/debounce state machine next state.
  always_comb begin
    row_m_d   = row;
    row_s_d   = row_m_q;
    div_d     = tick ? '0 : div_q + DW'(1);
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    pat_d     = pat_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    down_d    = down_q;
    value_d   = value_q;
    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (all_high) begin
            col_d = col_rot;
          end else begin
            col_idx_d = cur_col_idx;
            row_idx_d = cur_row_idx;
            pat_d     = row_s_q;
            cnt_d     = CW'(1);
            state_d   = (DEBOUNCE_TICKS == 1) ? ACCEPT : DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (row_s_q == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) state_d = ACCEPT;
          end else begin
            cnt_d   = '0;
            col_d   = col_rot;
            state_d = SCAN;
          end
        end
      end
      ACCEPT: begin
        code_d  = {row_idx_q, col_idx_q};
        valid_d = 1'b1;
        down_d  = 1'b1;
        value_d = {value_q[11:0], row_idx_q, col_idx_q};
        cnt_d   = '0;
        state_d = PRESSED;
      end
      PRESSED: begin
        if (tick) begin
          if (all_high) begin
            if (cnt_inc >= CNT_MAX) begin
              down_d  = 1'b0;
              cnt_d   = '0;
              col_d   = col_rot;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= SCAN;
      row_m_q   <= 4'b1111;
      row_s_q   <= 4'b1111;
      div_q     <= '0;
      cnt_q     <= '0;
      col_q     <= 4'b1110;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      pat_q     <= 4'b0000;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
      value_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      row_m_q   <= row_m_d;
      row_s_q   <= row_s_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      pat_q     <= pat_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      down_q    <= down_d;
      value_q   <= value_d;
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign value     = value_q;

endmodule
